stage_sequencer: RTL and testbench

Central controller that sequences the four execution phases of the Lua processor core: fetch, decode, execute and writeback. It replaces free-running phase clocks with one-cycle stage enables on a single clock, owns the program counter, handles memory/execute wait handshakes, and applies branch and conditional-skip updates. It sits between the top-level core and the fetch, decode, execute and writeback units.

---
 rtl/cpu_ctrl_pkg.sv | 36 +++
 rtl/ack_watchdog.sv | 42 ++++
 rtl/stage_sequencer.sv | 170 +++++++++++++++++
 tb/tb_stage_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: sequencer state encoding, PC width default, next-PC select codes.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    localparam int PC_WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_SKIP   = 2'd1,
        NPC_BRANCH = 2'd2
    } npc_sel_e;

    // A taken branch overrides a conditional skip; otherwise advance sequentially.
    function automatic npc_sel_e npc_select(input logic branch, input logic skip);
        npc_sel_e sel;
        sel = NPC_SEQ;
        if (branch) begin
            sel = NPC_BRANCH;
        end else if (skip) begin
            sel = NPC_SKIP;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Ack-wait watchdog: counts cycles spent waiting for an ack, flags the cycle that reaches the limit.
// Latency: timeout_o is combinational on the current count and count enable.
// Backpressure: none; the owner decides what an expired wait means.
module ack_watchdog #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic timeout_o
);

    localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The wait that would bring the count to ACK_TIMEOUT is the expiring one.
    assign timeout_o = cnt_en_i && (cnt_q == LAST);

    // Clear wins over counting; the counter saturates at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Sequences fetch/decode/execute/writeback with one-cycle enables; owns PC and retired count.
// Latency: 4 cycles per instruction minimum; each ex_busy or ack-wait cycle adds one.
// Backpressure: waits on imem_ack, ex_busy and wb_ack; an ack wait of ACK_TIMEOUT cycles -> ERROR.
module stage_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int                   PC_WIDTH    = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter int                   ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                imem_req,
    input  logic                imem_ack,
    output logic                if_en,
    output logic                id_en,
    output logic                ex_en,
    input  logic                ex_busy,
    input  logic                branch_valid,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                skip_next,
    input  logic                halt_req,
    output logic                wb_req,
    input  logic                wb_ack,
    output logic                wb_en,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         retired,
    output logic                halted,
    output logic                error
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = 1;
    localparam logic [PC_WIDTH-1:0] PC_TWO = 2;

    state_e              state_q,     state_d;
    logic [PC_WIDTH-1:0] pc_q,        pc_d;
    logic [31:0]         retired_q,   retired_d;
    npc_sel_e            npc_sel_q,   npc_sel_d;
    logic [PC_WIDTH-1:0] target_q,    target_d;
    logic                halt_pend_q, halt_pend_d;
    logic                ex_first_q,  ex_first_d;

    logic wd_cnt_en;
    logic wd_timeout;

    // Any state change restarts the wait count, so FETCH and WB each start from zero.
    ack_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_d != state_q),
        .cnt_en_i  (wd_cnt_en),
        .timeout_o (wd_timeout)
    );

    assign pc      = pc_q;
    assign retired = retired_q;
    assign halted  = (state_q == ST_HALT);
    assign error   = (state_q == ST_ERROR);

    // Next state, strobes and the WB-time PC/retired update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        npc_sel_d   = npc_sel_q;
        target_d    = target_q;
        halt_pend_d = halt_pend_q;
        ex_first_d  = 1'b0;
        imem_req    = 1'b0;
        if_en       = 1'b0;
        id_en       = 1'b0;
        ex_en       = 1'b0;
        wb_req      = 1'b0;
        wb_en       = 1'b0;
        wd_cnt_en   = 1'b0;

        if (halt_req && (state_q inside {ST_DECODE, ST_EXEC, ST_WB})) begin
            halt_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if_en   = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    wd_cnt_en = 1'b1;
                    if (wd_timeout) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DECODE: begin
                id_en      = 1'b1;
                ex_first_d = 1'b1;
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                ex_en = ex_first_q;
                if (!ex_busy) begin
                    npc_sel_d = npc_select(branch_valid, skip_next);
                    target_d  = branch_target;
                    state_d   = ST_WB;
                end
            end
            ST_WB: begin
                wb_req = 1'b1;
                if (wb_ack) begin
                    wb_en     = 1'b1;
                    retired_d = retired_q + 32'd1;
                    case (npc_sel_q)
                        NPC_BRANCH: pc_d = target_q;
                        NPC_SKIP:   pc_d = pc_q + PC_TWO;
                        default:    pc_d = pc_q + PC_ONE;
                    endcase
                    halt_pend_d = 1'b0;
                    if (halt_pend_q || halt_req) begin
                        state_d = ST_HALT;
                    end else if (!run) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    wd_cnt_en = 1'b1;
                    if (wd_timeout) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_HALT, ST_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    // State, PC, retired count and per-instruction latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            retired_q   <= '0;
            npc_sel_q   <= NPC_SEQ;
            target_q    <= '0;
            halt_pend_q <= 1'b0;
            ex_first_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            retired_q   <= retired_d;
            npc_sel_q   <= npc_sel_d;
            target_q    <= target_d;
            halt_pend_q <= halt_pend_d;
            ex_first_q  <= ex_first_d;
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Runs with ACK_TIMEOUT=4 so watchdog limits are reachable in a few cycles.
module tb_stage_sequencer;

    localparam int PCW = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           run;
    logic           imem_req;
    logic           imem_ack;
    logic           if_en;
    logic           id_en;
    logic           ex_en;
    logic           ex_busy;
    logic           branch_valid;
    logic [PCW-1:0] branch_target;
    logic           skip_next;
    logic           halt_req;
    logic           wb_req;
    logic           wb_ack;
    logic           wb_en;
    logic [PCW-1:0] pc;
    logic [31:0]    retired;
    logic           halted;
    logic           error;

    logic [3:0]     strb;
    int             n_cmp = 0;
    int             n_mis = 0;

    logic [3:0]     pat [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    assign strb = {if_en, id_en, ex_en, wb_en};

    always #5 clk = ~clk;

    stage_sequencer #(
        .PC_WIDTH    (PCW),
        .RESET_PC    (32'd0),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .if_en         (if_en),
        .id_en         (id_en),
        .ex_en         (ex_en),
        .ex_busy       (ex_busy),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .skip_next     (skip_next),
        .halt_req      (halt_req),
        .wb_req        (wb_req),
        .wb_ack        (wb_ack),
        .wb_en         (wb_en),
        .pc            (pc),
        .retired       (retired),
        .halted        (halted),
        .error         (error)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction with immediate acks and ex_busy low; entered during a FETCH cycle,
    // returns during the first cycle after WB. Branch/skip are driven only in EXEC.
    task automatic instr(input string tag, input logic bv, input logic [31:0] tgt, input logic sk);
        #1;
        expect_eq({tag, " if"}, strb, 4'b1000);
        tick(); #1;
        expect_eq({tag, " id"}, strb, 4'b0100);
        tick();
        branch_valid = bv; branch_target = tgt; skip_next = sk;
        #1;
        expect_eq({tag, " ex"}, strb, 4'b0010);
        tick();
        branch_valid = 1'b0; branch_target = 32'hDEAD_BEEF; skip_next = 1'b0;
        #1;
        expect_eq({tag, " wb"}, strb, 4'b0001);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck, expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; wb_ack = 1'b0; ex_busy = 1'b0;
        branch_valid = 1'b0; branch_target = '0; skip_next = 1'b0; halt_req = 1'b0;

        // Reset state
        #12;
        expect_eq("reset outs", {imem_req, wb_req, halted, error, strb}, 8'h00);
        expect_eq("reset pc", pc, 32'd0);
        expect_eq("reset retired", retired, 32'd0);

        @(posedge clk); #1;
        reset = 1'b0; run = 1'b1; imem_ack = 1'b1; wb_ack = 1'b1;
        #1;
        expect_eq("idle outs", {imem_req, strb}, 5'b0);

        // Back-to-back 4-cycle instructions
        for (int k = 0; k < 12; k++) begin
            tick(); #1;
            expect_eq($sformatf("stream strb %0d", k), strb, pat[k % 4]);
            if (k % 4 == 0) expect_eq($sformatf("stream pc %0d", k), pc, 32'(k / 4));
        end

        // Slow instruction: 2 imem waits, 3 busy cycles -> 9 cycles
        tick();
        imem_ack = 1'b0;
        #1;
        expect_eq("stream retired", retired, 32'd3);
        expect_eq("stream pc3", pc, 32'd3);
        expect_eq("fetch wait1", {imem_req, strb}, 5'b10000);
        tick(); #1;
        expect_eq("fetch wait2", {imem_req, strb}, 5'b10000);
        tick(); imem_ack = 1'b1; #1;
        expect_eq("if on ack", strb, 4'b1000);
        tick(); ex_busy = 1'b1; #1;
        expect_eq("slow id", strb, 4'b0100);
        tick(); #1;
        expect_eq("ex entry busy", strb, 4'b0010);
        tick(); #1;
        expect_eq("ex busy2", strb, 4'b0000);
        tick(); #1;
        expect_eq("ex busy3", strb, 4'b0000);
        tick(); ex_busy = 1'b0; #1;
        expect_eq("ex final", strb, 4'b0000);
        tick(); #1;
        expect_eq("slow wb", strb, 4'b0001);
        tick(); #1;
        expect_eq("slow pc", pc, 32'd4);
        expect_eq("slow retired", retired, 32'd4);

        // PC update priority and wrap
        instr("br10", 1'b1, 32'd10, 1'b0);
        expect_eq("pc br10", pc, 32'd10);
        instr("skip", 1'b0, 32'd0, 1'b1);
        expect_eq("pc skip", pc, 32'd12);
        instr("br+skip", 1'b1, 32'h40, 1'b1);
        expect_eq("pc br+skip", pc, 32'h40);
        expect_eq("retired7", retired, 32'd7);
        instr("brmax", 1'b1, 32'hFFFF_FFFF, 1'b0);
        expect_eq("pc max", pc, 32'hFFFF_FFFF);
        instr("wrap", 1'b0, 32'd0, 1'b0);
        expect_eq("pc wrap", pc, 32'd0);
        instr("brmax2", 1'b1, 32'hFFFF_FFFF, 1'b0);
        instr("skipwrap", 1'b0, 32'd0, 1'b1);
        expect_eq("pc skipwrap", pc, 32'd1);
        expect_eq("retired11", retired, 32'd11);

        // run dropped during EXEC: instruction retires, then IDLE, then resume
        #1;
        expect_eq("rd if", strb, 4'b1000);
        tick();
        tick(); run = 1'b0; #1;
        expect_eq("rd ex", strb, 4'b0010);
        tick(); #1;
        expect_eq("rd wb", strb, 4'b0001);
        tick(); #1;
        expect_eq("rd idle", {imem_req, strb}, 5'b0);
        expect_eq("rd pc", pc, 32'd2);
        expect_eq("rd retired", retired, 32'd12);
        tick(); run = 1'b1; #1;
        expect_eq("rd still idle", imem_req, 1'b0);
        tick(); #1;
        expect_eq("rd resume req", imem_req, 1'b1);
        expect_eq("rd resume pc", pc, 32'd2);

        // halt_req pulsed in DECODE
        tick(); halt_req = 1'b1; #1;
        expect_eq("halt id", strb, 4'b0100);
        tick(); halt_req = 1'b0; #1;
        tick(); #1;
        expect_eq("halt wb", strb, 4'b0001);
        tick(); #1;
        expect_eq("halted", halted, 1'b1);
        expect_eq("halt retired", retired, 32'd13);
        expect_eq("halt pc", pc, 32'd3);
        for (int k = 0; k < 3; k++) tick();
        #1;
        expect_eq("halt no req", {imem_req, halted}, 2'b01);

        // Async reset out of HALT, between clock edges
        #2 reset = 1'b1;
        #1;
        expect_eq("rst halted", halted, 1'b0);
        expect_eq("rst pc", pc, 32'd0);
        expect_eq("rst retired", retired, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // wb_ack withheld -> ERROR after 4 WB cycles
        tick();
        instr("pre", 1'b0, 32'd0, 1'b0);
        expect_eq("pre pc", pc, 32'd1);
        tick();
        tick(); wb_ack = 1'b0; #1;
        expect_eq("to ex", strb, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            expect_eq($sformatf("wb wait %0d", k), {wb_req, error}, 2'b10);
        end
        tick(); #1;
        expect_eq("error", {wb_req, error}, 2'b01);
        expect_eq("err pc", pc, 32'd1);
        expect_eq("err retired", retired, 32'd1);
        tick(); wb_ack = 1'b1; #1;
        tick(); #1;
        expect_eq("error sticky", {imem_req, error}, 2'b01);
        #2 reset = 1'b1;
        #1;
        expect_eq("rst error", {error, imem_req}, 2'b00);
        expect_eq("rst pc2", pc, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // imem_ack arriving on the cycle the count reaches the limit wins
        imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            expect_eq($sformatf("fetch hold %0d", k), {imem_req, error, strb}, 6'b100000);
        end
        tick(); imem_ack = 1'b1; #1;
        expect_eq("ack at limit", {error, strb}, 5'b01000);
        tick(); #1;
        expect_eq("after limit", {error, strb}, 5'b00100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
